// File: rtl/spi_reg_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl_if
// Groups the four SPI pins and the MISO output enable into one bundle.
// Signal names take the device's point of view.
//   spi_cs_i      chip select, active-low
//   spi_sclk_i    SPI clock, mode 0
//   spi_mosi_i    host -> device data, MSB first
//   spi_miso_o    device -> host data
//   spi_miso_oe_o MISO pad output enable
// The slave modport is for the register controller. The master modport is for
// the host or testbench side.
// ---------------------------------------------------------------------------
interface spi_reg_ctrl_if;
    logic spi_cs_i;
    logic spi_sclk_i;
    logic spi_mosi_i;
    logic spi_miso_o;
    logic spi_miso_oe_o;

    modport slave (
        input  spi_cs_i,
        input  spi_sclk_i,
        input  spi_mosi_i,
        output spi_miso_o,
        output spi_miso_oe_o
    );

    modport master (
        output spi_cs_i,
        output spi_sclk_i,
        output spi_mosi_i,
        input  spi_miso_o,
        input  spi_miso_oe_o
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
// SPI-slave register controller. It decodes 16-bit frames {W, A[6:0], D[7:0]}
// into accesses on a small register bank:
//   0x00 ID (RO)
//   0x01 PORT_OUT (RW)
//   0x02 PORT_IN (RO)
//   0x03 SCRATCH (RW)
//   0x04 FRAME_CNT (RO)
// Ports:
//   clk, rst      system clock; asynchronous active-high reset
//   spi           SPI pins, slave modport of spi_reg_ctrl_if
//   port_i        mixed-signal input; synchronized, read at 0x02
//   port_o        register 0x01
//   wr_strobe_o   one-cycle pulse when a write commits
//   wr_addr_o     address of the last committed write
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter logic [7:0] ID_VALUE     = 8'hD1,
    parameter logic [7:0] PORT_O_RESET = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    spi_reg_ctrl_if.slave  spi,
    input  logic [7:0]     port_i,
    output logic [7:0]     port_o,
    output logic           wr_strobe_o,
    output logic [6:0]     wr_addr_o
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_COMMIT, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        cs_s1_q, cs_s2_q, cs_prev_q;
    logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [7:0]  port_s1_q, port_s2_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        w_q, w_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  miso_sr_q, miso_sr_d;
    logic        miso_q, miso_d;
    logic [7:0]  port_out_q, port_out_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic        rise, fall, cs_fall, cs_rise;
    logic [6:0]  cmd_addr;
    logic [7:0]  rd_data;

    assign rise    =  sclk_s2_q & ~sclk_prev_q;
    assign fall    = ~sclk_s2_q &  sclk_prev_q;
    assign cs_fall = ~cs_s2_q   &  cs_prev_q;
    assign cs_rise =  cs_s2_q   & ~cs_prev_q;

    // Address as it stands once the 8th command bit is shifted in.
    assign cmd_addr = {shift_q[5:0], mosi_s2_q};

    always_comb begin
        case (cmd_addr)
            7'h00:   rd_data = ID_VALUE;
            7'h01:   rd_data = port_out_q;
            7'h02:   rd_data = port_s2_q;
            7'h03:   rd_data = scratch_q;
            7'h04:   rd_data = frame_cnt_q;
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        w_d         = w_q;
        addr_d      = addr_q;
        miso_sr_d   = miso_sr_q;
        miso_d      = 1'b0;
        port_out_d  = port_out_q;
        scratch_d   = scratch_q;
        frame_cnt_d = frame_cnt_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            S_CMD: begin
                if (cs_rise) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    shift_d = {shift_q[6:0], mosi_s2_q};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        w_d       = shift_q[6];
                        addr_d    = cmd_addr;
                        miso_sr_d = rd_data;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                miso_d = miso_q;
                if (cs_rise) begin
                    miso_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (rise) begin
                    shift_d = {shift_q[6:0], mosi_s2_q};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        miso_d  = 1'b0;
                        state_d = S_COMMIT;
                    end
                end else if (fall) begin
                    miso_d    = miso_sr_q[7];
                    miso_sr_d = {miso_sr_q[6:0], 1'b0};
                end
            end
            S_COMMIT: begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                if (w_q) begin
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_q;
                    if (addr_q == 7'h01) port_out_d = shift_q;
                    if (addr_q == 7'h03) scratch_d  = shift_q;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Level test: a CS rise that lands during COMMIT must still release WAIT.
                if (cs_s2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            port_s1_q   <= '0;
            port_s2_q   <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            w_q         <= 1'b0;
            addr_q      <= '0;
            miso_sr_q   <= '0;
            miso_q      <= 1'b0;
            port_out_q  <= PORT_O_RESET;
            scratch_q   <= '0;
            frame_cnt_q <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cs_s1_q     <= spi.spi_cs_i;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            sclk_s1_q   <= spi.spi_sclk_i;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= spi.spi_mosi_i;
            mosi_s2_q   <= mosi_s1_q;
            port_s1_q   <= port_i;
            port_s2_q   <= port_s1_q;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            miso_sr_q   <= miso_sr_d;
            miso_q      <= miso_d;
            port_out_q  <= port_out_d;
            scratch_q   <= scratch_d;
            frame_cnt_q <= frame_cnt_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign spi.spi_miso_o    = miso_q;
    assign spi.spi_miso_oe_o = ~cs_s2_q;
    assign port_o            = port_out_q;
    assign wr_strobe_o       = wr_strobe_q;
    assign wr_addr_o         = wr_addr_q;

endmodule
